// File: rtl/hp_to_int_seq.sv
// FP16 to signed int16 converter (truncate toward zero) with an iterative
// one-bit-per-cycle alignment shifter behind valid/ready handshakes.
module hp_to_int_seq (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] hp_in,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] int_out,
   output logic [1:0]  ex_flag
);

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e      state_q, state_d;
   logic        sign_q, sign_d;
   logic [15:0] mag_q, mag_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        dir_left_q, dir_left_d;
   logic        stk_q, stk_d;
   logic        spec_q, spec_d;
   logic [1:0]  spec_flag_q, spec_flag_d;
   logic [15:0] int_out_q, int_out_d;
   logic [1:0]  ex_flag_q, ex_flag_d;

   logic        in_sign;
   logic [4:0]  in_exp;
   logic [9:0]  in_frac;
   logic [15:0] in_sat;

   assign in_sign = hp_in[15];
   assign in_exp  = hp_in[14:10];
   assign in_frac = hp_in[9:0];
   assign in_sat  = in_sign ? 16'h8000 : 16'h7FFF;

   assign in_ready  = (state_q == StIdle);
   assign out_valid = (state_q == StDone);
   assign int_out   = int_out_q;
   assign ex_flag   = ex_flag_q;

   always_comb begin
      state_d     = state_q;
      sign_d      = sign_q;
      mag_d       = mag_q;
      cnt_d       = cnt_q;
      dir_left_d  = dir_left_q;
      stk_d       = stk_q;
      spec_d      = spec_q;
      spec_flag_d = spec_flag_q;
      int_out_d   = int_out_q;
      ex_flag_d   = ex_flag_q;

      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               sign_d      = in_sign;
               cnt_d       = 4'd0;
               dir_left_d  = 1'b0;
               stk_d       = 1'b0;
               spec_d      = 1'b0;
               spec_flag_d = 2'b00;
               state_d     = StShift;
               if (in_exp == 5'd31) begin
                  mag_d       = in_sat;
                  spec_d      = 1'b1;
                  spec_flag_d = 2'b11;
               end else if (in_exp == 5'd30 && !(in_sign && in_frac == 10'd0)) begin
                  mag_d       = in_sat;
                  spec_d      = 1'b1;
                  spec_flag_d = 2'b01;
               end else if (in_exp >= 5'd25) begin
                  // Low 4 bits suffice: e-25 is 0..5 over this range.
                  mag_d      = {5'd0, 1'b1, in_frac};
                  dir_left_d = 1'b1;
                  cnt_d      = in_exp[3:0] - 4'd9;
               end else if (in_exp >= 5'd15) begin
                  mag_d = {5'd0, 1'b1, in_frac};
                  cnt_d = 4'd9 - in_exp[3:0];
               end else begin
                  // |x| < 1 truncates to zero; any nonzero input is inexact.
                  mag_d = 16'd0;
                  stk_d = (in_exp != 5'd0) || (in_frac != 10'd0);
               end
            end
         end
         StShift: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
               if (dir_left_q) begin
                  mag_d = {mag_q[14:0], 1'b0};
               end else begin
                  mag_d = {1'b0, mag_q[15:1]};
                  stk_d = stk_q | mag_q[0];
               end
            end else begin
               int_out_d = sign_q ? (~mag_q + 16'd1) : mag_q;
               ex_flag_d = spec_q ? spec_flag_q : {stk_q, 1'b0};
               state_d   = StDone;
            end
         end
         StDone: begin
            if (out_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         sign_q      <= 1'b0;
         mag_q       <= 16'd0;
         cnt_q       <= 4'd0;
         dir_left_q  <= 1'b0;
         stk_q       <= 1'b0;
         spec_q      <= 1'b0;
         spec_flag_q <= 2'b00;
         int_out_q   <= 16'd0;
         ex_flag_q   <= 2'b00;
      end else begin
         state_q     <= state_d;
         sign_q      <= sign_d;
         mag_q       <= mag_d;
         cnt_q       <= cnt_d;
         dir_left_q  <= dir_left_d;
         stk_q       <= stk_d;
         spec_q      <= spec_d;
         spec_flag_q <= spec_flag_d;
         int_out_q   <= int_out_d;
         ex_flag_q   <= ex_flag_d;
      end
   end

endmodule

// File: tb/tb_hp_to_int_seq.sv
// Directed bench for hp_to_int_seq: hand-computed results, latencies,
// backpressure and mid-conversion reset.
module tb_hp_to_int_seq;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] hp_in;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] int_out;
   logic [1:0]  ex_flag;

   int passed;
   int total;

   hp_to_int_seq dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .hp_in     (hp_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .int_out   (int_out),
      .ex_flag   (ex_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got 0x%04h, expected 0x%04h", tag, got, exp);
   endtask

   // Accept one word and wait (bounded) for out_valid; result stays in DONE.
   task automatic convert(input logic [15:0] w, input logic [15:0] exp_int,
                          input logic [1:0] exp_flag, input int exp_lat);
      int  lat;
      logic rdy_low;
      @(negedge clk);
      hp_in    = w;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat      = 0;
      rdy_low  = 1'b1;
      while (!out_valid && lat < 20) begin
         if (in_ready) rdy_low = 1'b0;
         @(posedge clk);
         #1;
         lat++;
      end
      if (in_ready) rdy_low = 1'b0;
      check($sformatf("lat %04h", w), 16'(lat), 16'(exp_lat));
      check($sformatf("valid %04h", w), {15'd0, out_valid}, 16'd1);
      check($sformatf("int %04h", w), int_out, exp_int);
      check($sformatf("flag %04h", w), {14'd0, ex_flag}, {14'd0, exp_flag});
      check($sformatf("busy %04h", w), {15'd0, rdy_low}, 16'd1);
   endtask

   task automatic release_out();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("hs valid", {15'd0, out_valid}, 16'd0);
      check("hs ready", {15'd0, in_ready}, 16'd1);
   endtask

   task automatic run(input logic [15:0] w, input logic [15:0] exp_int,
                      input logic [1:0] exp_flag, input int exp_lat);
      convert(w, exp_int, exp_flag, exp_lat);
      release_out();
   endtask

   initial begin
      passed    = 0;
      total     = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      hp_in     = 16'h0000;
      out_ready = 1'b0;
      #12;
      check("rst int", int_out, 16'h0000);
      check("rst flag", {14'd0, ex_flag}, 16'd0);
      check("rst valid", {15'd0, out_valid}, 16'd0);
      check("rst ready", {15'd0, in_ready}, 16'd1);
      @(negedge clk);
      rst_n = 1'b1;

      run(16'h3C00, 16'h0001, 2'b00, 11);
      run(16'hC500, 16'hFFFB, 2'b00, 9);
      run(16'hF800, 16'h8000, 2'b00, 6);
      run(16'h7BFF, 16'h7FFF, 2'b01, 1);
      run(16'h7C00, 16'h7FFF, 2'b11, 1);
      run(16'h7E00, 16'h7FFF, 2'b11, 1);
      run(16'hFC00, 16'h8000, 2'b11, 1);
      run(16'h3E00, 16'h0001, 2'b10, 11);
      run(16'h3800, 16'h0000, 2'b10, 1);
      run(16'h8000, 16'h0000, 2'b00, 1);

      // Backpressure: result must hold and an in_valid pulse is ignored.
      convert(16'h4900, 16'h000A, 2'b00, 8);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_valid = (i == 2);
         hp_in    = 16'h3C00;
         @(posedge clk);
         #1;
         check("bp valid", {15'd0, out_valid}, 16'd1);
         check("bp int", int_out, 16'h000A);
         check("bp flag", {14'd0, ex_flag}, 16'd0);
         check("bp ready", {15'd0, in_ready}, 16'd0);
      end
      @(negedge clk);
      in_valid = 1'b0;
      release_out();
      @(posedge clk);
      #1;
      check("bp no ghost", {15'd0, out_valid}, 16'd0);

      // Reset mid-SHIFT discards the conversion.
      @(negedge clk);
      hp_in    = 16'h3C00;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      check("mid busy", {15'd0, in_ready}, 16'd0);
      rst_n = 1'b0;
      #1;
      check("mid valid", {15'd0, out_valid}, 16'd0);
      check("mid ready", {15'd0, in_ready}, 16'd1);
      check("mid int", int_out, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      run(16'h4400, 16'h0004, 2'b00, 9);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
